// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge_event_detector block.
//   cnt_width()        : width of the debounce counter for a given filter length
//   INIT_LEVEL_DEFAULT : default reset level of synchroniser and filtered level
package edge_event_pkg;

  localparam logic INIT_LEVEL_DEFAULT = 1'b0;

  // Counter must hold 0..FILTER_CYCLES; never narrower than one bit.
  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = $clog2(filter_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_event_channel.sv
// One channel of the edge_event_detector:
// synchroniser -> debounce filter -> edge qualify -> sticky pending flag.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_input                : raw (possibly asynchronous) input
//   i_rise_en / i_fall_en  : report rising / falling edges
//   i_clear                : level-sensitive pending clear
//   o_level                : filtered level
//   o_pulse                : one-cycle pulse per accepted, enabled edge
//   o_pending              : sticky event flag
module edge_event_channel
  import edge_event_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic INIT_LEVEL    = INIT_LEVEL_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_input,
  input  logic i_rise_en,
  input  logic i_fall_en,
  input  logic i_clear,
  output logic o_level,
  output logic o_pulse,
  output logic o_pending
);

  localparam int             CW       = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic sample;

  // Synchroniser; zero stages means the input is already synchronous.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sample = i_input;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      // Shift in at bit 0; the cast drops the oldest bit.
      always_comb begin
        sync_d = SYNC_STAGES'({sync_q, i_input});
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        else       sync_q <= sync_d;
      end

      assign sample = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    // A sample matching the current level cancels any partial count.
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sample;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Enables only matter on the accepting cycle; level tracks regardless.
    pulse_d   = accept & (sample ? i_rise_en : i_fall_en);
    // Set wins over clear so a coinciding event is never lost.
    pending_d = (pending_q & ~i_clear) | pulse_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_q   <= INIT_LEVEL;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign o_level   = level_q;
  assign o_pulse   = pulse_q;
  assign o_pending = pending_q;

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel runtime-configurable edge detector with debounce.
// Ports:
//   i_clk, i_rst              : clock, synchronous active-high reset
//   iv_input                  : raw inputs, one per channel
//   iv_rise_en / iv_fall_en   : per-channel edge reporting enables
//   iv_clear                  : per-channel pending clear
//   ov_level                  : filtered levels
//   ov_pulse                  : one-cycle event pulses
//   ov_pending                : sticky event flags
//   o_any                     : OR of ov_pending
module edge_event_detector
  import edge_event_pkg::*;
#(
  parameter int   WIDTH         = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic INIT_LEVEL    = INIT_LEVEL_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] iv_input,
  input  logic [WIDTH-1:0] iv_rise_en,
  input  logic [WIDTH-1:0] iv_fall_en,
  input  logic [WIDTH-1:0] iv_clear,
  output logic [WIDTH-1:0] ov_level,
  output logic [WIDTH-1:0] ov_pulse,
  output logic [WIDTH-1:0] ov_pending,
  output logic             o_any
);

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      edge_event_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES),
        .INIT_LEVEL   (INIT_LEVEL)
      ) u_ch (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_input  (iv_input[g]),
        .i_rise_en(iv_rise_en[g]),
        .i_fall_en(iv_fall_en[g]),
        .i_clear  (iv_clear[g]),
        .o_level  (ov_level[g]),
        .o_pulse  (ov_pulse[g]),
        .o_pending(ov_pending[g])
      );
    end
  endgenerate

  assign o_any = |ov_pending;

endmodule

// File: tb/tb_edge_event_detector.sv
module tb_edge_event_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_in, a_rise, a_fall, a_clr;
  logic [3:0] a_level, a_pulse, a_pending;
  logic       a_any;
  logic [3:0] b_in, b_rise, b_fall, b_clr;
  logic [3:0] b_level, b_pulse, b_pending;
  logic       b_any;

  always #5 clk = ~clk;

  edge_event_detector #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .INIT_LEVEL(1'b0)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .iv_input(a_in), .iv_rise_en(a_rise), .iv_fall_en(a_fall),
    .iv_clear(a_clr), .ov_level(a_level), .ov_pulse(a_pulse), .ov_pending(a_pending), .o_any(a_any));

  edge_event_detector #(.WIDTH(4), .SYNC_STAGES(0), .FILTER_CYCLES(1), .INIT_LEVEL(1'b1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .iv_input(b_in), .iv_rise_en(b_rise), .iv_fall_en(b_fall),
    .iv_clear(b_clr), .ov_level(b_level), .ov_pulse(b_pulse), .ov_pending(b_pending), .o_any(b_any));

  typedef struct {
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] pending;
    logic       any;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pulse_cnt[4];
  int   rise_cyc[4];
  int   fall_cyc[4];

  // Reference model state, indexed [dut][channel].
  logic m_sync[2][4][4];
  logic m_lvl[2][4];
  int   m_cnt[2][4];
  logic m_pul[2][4];
  logic m_pend[2][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step(input int d, input int ns, input int nf, input logic init,
                            input logic r, input logic [3:0] in, input logic [3:0] ren,
                            input logic [3:0] fen, input logic [3:0] clr);
    for (int ch = 0; ch < 4; ch++) begin
      if (r) begin
        for (int s = 0; s < 4; s++) m_sync[d][ch][s] = init;
        m_lvl[d][ch]  = init;
        m_cnt[d][ch]  = 0;
        m_pul[d][ch]  = 1'b0;
        m_pend[d][ch] = 1'b0;
      end else begin
        logic smp, acc;
        smp = (ns == 0) ? in[ch] : m_sync[d][ch][ns-1];
        m_pend[d][ch] = (m_pend[d][ch] & ~clr[ch]) | m_pul[d][ch];
        acc = 1'b0;
        if (smp == m_lvl[d][ch]) m_cnt[d][ch] = 0;
        else if (m_cnt[d][ch] == nf - 1) begin
          m_lvl[d][ch] = smp;
          m_cnt[d][ch] = 0;
          acc = 1'b1;
        end else m_cnt[d][ch] = m_cnt[d][ch] + 1;
        m_pul[d][ch] = acc & (smp ? ren[ch] : fen[ch]);
        for (int s = ns - 1; s >= 1; s--) m_sync[d][ch][s] = m_sync[d][ch][s-1];
        if (ns > 0) m_sync[d][ch][0] = in[ch];
      end
    end
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    for (int ch = 0; ch < 4; ch++) begin
      e.level[ch]   = m_lvl[d][ch];
      e.pulse[ch]   = m_pul[d][ch];
      e.pending[ch] = m_pend[d][ch];
    end
    e.any = |e.pending;
    return e;
  endfunction

  // One clock: predict, push to scoreboard, clock, then pop and compare at negedge.
  task automatic cycle();
    exp_t e;
    model_step(0, 2, 4, 1'b0, rst, a_in, a_rise, a_fall, a_clr);
    sb_q.push_back(model_out(0));
    model_step(1, 0, 1, 1'b1, rst, b_in, b_rise, b_fall, b_clr);
    sb_q.push_back(model_out(1));
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = sb_q.pop_front();
    chk("a_level", {28'd0, a_level}, {28'd0, e.level});
    chk("a_pulse", {28'd0, a_pulse}, {28'd0, e.pulse});
    chk("a_pending", {28'd0, a_pending}, {28'd0, e.pending});
    chk("a_any", {31'd0, a_any}, {31'd0, e.any});
    e = sb_q.pop_front();
    chk("b_level", {28'd0, b_level}, {28'd0, e.level});
    chk("b_pulse", {28'd0, b_pulse}, {28'd0, e.pulse});
    chk("b_pending", {28'd0, b_pending}, {28'd0, e.pending});
    chk("b_any", {31'd0, b_any}, {31'd0, e.any});
    for (int ch = 0; ch < 4; ch++) begin
      if (a_pulse[ch]) begin
        pulse_cnt[ch]++;
        if (a_level[ch]) rise_cyc[ch] = cyc;
        else             fall_cyc[ch] = cyc;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int  base;
    logic seen;
    for (int ch = 0; ch < 4; ch++) begin
      pulse_cnt[ch] = 0; rise_cyc[ch] = 0; fall_cyc[ch] = 0;
    end
    rst = 1'b1;
    a_in = 4'h0; a_rise = 4'hF; a_fall = 4'h0; a_clr = 4'h0;
    b_in = 4'hF; b_rise = 4'hF; b_fall = 4'hF; b_clr = 4'h0;

    // Reset state
    run(3);
    chk("rst_level", {28'd0, a_level}, 32'h0);
    chk("rst_pulse", {28'd0, a_pulse}, 32'h0);
    chk("rst_pending", {28'd0, a_pending}, 32'h0);
    chk("rst_any", {31'd0, a_any}, 32'h0);
    chk("rst_b_level", {28'd0, b_level}, 32'hF);
    rst = 1'b0;
    run(2);

    // Latency: rise on ch0 appears on the 6th edge
    a_in[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("lat_early_pulse", {31'd0, a_pulse[0]}, 32'd0);
    end
    cycle();
    chk("lat_pulse", {31'd0, a_pulse[0]}, 32'd1);
    chk("lat_level", {31'd0, a_level[0]}, 32'd1);
    cycle();
    chk("lat_pulse_once", {31'd0, a_pulse[0]}, 32'd0);
    chk("lat_pending", {31'd0, a_pending[0]}, 32'd1);
    chk("lat_any", {31'd0, a_any}, 32'd1);

    // Glitch rejection on ch1
    a_fall[1] = 1'b1;
    base = pulse_cnt[1];
    a_in[1] = 1'b1; run(3);
    a_in[1] = 1'b0; run(10);
    chk("glitch_level", {31'd0, a_level[1]}, 32'd0);
    chk("glitch_nopulse", pulse_cnt[1] - base, 32'd0);
    a_in[1] = 1'b1; run(4);
    a_in[1] = 1'b0; run(12);
    chk("accept_pulses", pulse_cnt[1] - base, 32'd2);
    chk("rise_fall_gap", fall_cyc[1] - rise_cyc[1], 32'd4);

    // Mode masking on ch2: falls only
    a_rise = 4'h0; a_fall = 4'b0100;
    base = pulse_cnt[2];
    a_in[2] = 1'b1; run(10);
    chk("mask_level_hi", {31'd0, a_level[2]}, 32'd1);
    chk("mask_no_rise", pulse_cnt[2] - base, 32'd0);
    a_in[2] = 1'b0; run(10);
    chk("mask_level_lo", {31'd0, a_level[2]}, 32'd0);
    chk("mask_one_fall", pulse_cnt[2] - base, 32'd1);

    // Clear vs set on ch3
    a_clr = 4'hF; cycle();
    a_clr = 4'h0; cycle();
    chk("clr_all_any", {31'd0, a_any}, 32'd0);
    a_rise = 4'b1000;
    a_in[3] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (a_pulse[3]) seen = 1'b1;
    end
    chk("clr_pulse_seen", {31'd0, seen}, 32'd1);
    a_clr[3] = 1'b1; cycle();
    chk("set_wins", {31'd0, a_pending[3]}, 32'd1);
    cycle();
    chk("clr_takes", {31'd0, a_pending[3]}, 32'd0);
    chk("clr_any", {31'd0, a_any}, 32'd0);
    a_clr = 4'h0;

    // Reset mid-count on ch0
    a_in = 4'h0; a_rise = 4'hF; a_fall = 4'h0;
    run(12);
    a_in[0] = 1'b1;
    run(4);
    base = pulse_cnt[0];
    rst = 1'b1; run(2);
    chk("midrst_nopulse", pulse_cnt[0] - base, 32'd0);
    chk("midrst_level", {31'd0, a_level[0]}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("postrst_early", {31'd0, a_pulse[0]}, 32'd0);
    end
    cycle();
    chk("postrst_pulse", {31'd0, a_pulse[0]}, 32'd1);
    run(2);

    // Parameter sweep instance: SYNC=0, FILTER=1, INIT=1
    b_in[0] = 1'b0; cycle();
    chk("b_fall_pulse", {31'd0, b_pulse[0]}, 32'd1);
    chk("b_fall_level", {31'd0, b_level[0]}, 32'd0);
    b_in = 4'hF; cycle();
    b_in = 4'h0; cycle();
    chk("b_all_pulse", {28'd0, b_pulse}, 32'hF);
    chk("b_all_level", {28'd0, b_level}, 32'h0);
    cycle();
    chk("b_all_pending", {28'd0, b_pending}, 32'hF);
    chk("b_any", {31'd0, b_any}, 32'd1);
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
